irq_pending_latch: RTL and testbench

//   Request-capture stage that sits directly upstream of the 8-to-3 priority encoder.
//   It edge-detects N asynchronous request lines and holds each event in a sticky pending bit.
//   It applies an enable mask and drives the masked pending vector into the encoder input.
//   The consumer acknowledges a serviced index, which clears that pending bit.

---
 rtl/irq_pending_latch.sv | 76 +++++++
 tb/tb_irq_pending_latch.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Edge-detecting, sticky pending-request latch with per-line overflow, enable mask and indexed acknowledge.
// Optional IRQ_SYNC_EN adds a 2-flop synchronizer per request line (2 extra cycles of latency).
module irq_pending_latch #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     mask_i,
  input  logic             ack_i,
  input  logic [IDX_W-1:0] ack_idx_i,
  output logic [N-1:0]     pend_o,
  output logic             irq_o,
  output logic [N-1:0]     ovf_o
);

  logic [N-1:0] req_s;
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] ovf_q, ovf_d;
  logic [N-1:0] req_edge;
  logic [N-1:0] ack_vec;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous request lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_i;
`endif

  assign req_edge = req_s & ~prev_q;

  // Decode acknowledge; indices >= N never match any line
  always_comb begin
    ack_vec = '0;
    for (int unsigned k = 0; k < N; k++) begin
      ack_vec[k] = ack_i && (ack_idx_i == IDX_W'(k));
    end
  end

  // Set beats clear on pending; an acknowledged line never flags overflow
  always_comb begin
    pend_d = (pend_q & ~ack_vec) | req_edge;
    ovf_d  = (ovf_q | (req_edge & pend_q)) & ~ack_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      prev_q <= req_s;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend_o = pend_q & mask_i;
  assign irq_o  = |pend_o;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed, table-driven bench for irq_pending_latch in its default (unsynchronized) build.
module tb_irq_pending_latch;

  logic       clk;
  logic       rst;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       ack_i;
  logic [2:0] ack_idx_i;
  logic [7:0] pend_o;
  logic       irq_o;
  logic [7:0] ovf_o;

  int n_cmp;
  int n_err;

  typedef struct {
    string      name;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] idx;
    logic       clk_en;
    logic [7:0] exp_pend;
    logic       exp_irq;
    logic [7:0] exp_ovf;
  } vec_t;

  vec_t vecs[$];

  irq_pending_latch #(.N(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .mask_i    (mask_i),
    .ack_i     (ack_i),
    .ack_idx_i (ack_idx_i),
    .pend_o    (pend_o),
    .irq_o     (irq_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [7:0] req, input logic [7:0] mask,
                     input logic ack, input logic [2:0] idx, input logic clk_en,
                     input logic [7:0] ep, input logic ei, input logic [7:0] eo);
    vec_t v;
    v.name = name; v.req = req; v.mask = mask; v.ack = ack; v.idx = idx;
    v.clk_en = clk_en; v.exp_pend = ep; v.exp_irq = ei; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  function automatic int prio_enc(input logic [7:0] v);
    prio_enc = -1;
    for (int i = 0; i < 8; i++) if (v[i]) prio_enc = i;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Drain all eight reset-release events one index at a time
    add("ack0",      8'h00, 8'hFF, 1, 3'd0, 1, 8'hFE, 1, 8'h00);
    add("ack1",      8'h00, 8'hFF, 1, 3'd1, 1, 8'hFC, 1, 8'h00);
    add("ack2",      8'h00, 8'hFF, 1, 3'd2, 1, 8'hF8, 1, 8'h00);
    add("ack3",      8'h00, 8'hFF, 1, 3'd3, 1, 8'hF0, 1, 8'h00);
    add("ack4",      8'h00, 8'hFF, 1, 3'd4, 1, 8'hE0, 1, 8'h00);
    add("ack5",      8'h00, 8'hFF, 1, 3'd5, 1, 8'hC0, 1, 8'h00);
    add("ack6",      8'h00, 8'hFF, 1, 3'd6, 1, 8'h80, 1, 8'h00);
    add("ack7",      8'h00, 8'hFF, 1, 3'd7, 1, 8'h00, 0, 8'h00);
    add("single",    8'h30, 8'hFF, 0, 3'd6, 1, 8'h30, 1, 8'h00);
    add("ack_idx5",  8'h30, 8'hFF, 1, 3'd5, 1, 8'h10, 1, 8'h00);
    add("ack_idx4",  8'h30, 8'hFF, 1, 3'd4, 1, 8'h00, 0, 8'h00);
    add("hold_ackn", 8'h30, 8'hFF, 1, 3'd2, 1, 8'h00, 0, 8'h00);
    add("ovf_set1",  8'h02, 8'hFF, 0, 3'd0, 1, 8'h02, 1, 8'h00);
    add("ovf_low",   8'h00, 8'hFF, 0, 3'd0, 1, 8'h02, 1, 8'h00);
    add("ovf_again", 8'h02, 8'hFF, 0, 3'd0, 1, 8'h02, 1, 8'h02);
    add("ovf_ack",   8'h00, 8'hFF, 1, 3'd1, 1, 8'h00, 0, 8'h00);
    add("col_set",   8'h80, 8'hFF, 0, 3'd0, 1, 8'h80, 1, 8'h00);
    add("col_low",   8'h00, 8'hFF, 0, 3'd0, 1, 8'h80, 1, 8'h00);
    add("col_hit",   8'h80, 8'hFF, 1, 3'd7, 1, 8'h80, 1, 8'h00);
    add("mask_set",  8'h20, 8'h0F, 0, 3'd0, 1, 8'h00, 0, 8'h00);
    add("unmask",    8'h20, 8'hFF, 0, 3'd0, 0, 8'hA0, 1, 8'h00);
    add("mask_low",  8'h00, 8'h0F, 0, 3'd0, 1, 8'h00, 0, 8'h00);
    add("mask_ovf",  8'h20, 8'h0F, 0, 3'd0, 1, 8'h00, 0, 8'h20);
    add("unmask2",   8'h20, 8'hFF, 0, 3'd0, 1, 8'hA0, 1, 8'h20);

    // Reset with every line requesting
    rst = 1'b1; req_i = 8'hFF; mask_i = 8'hFF; ack_i = 1'b0; ack_idx_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pend", 32'(pend_o), 32'h00);
    check("rst_irq",  32'(irq_o),  32'h0);
    check("rst_ovf",  32'(ovf_o),  32'h00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("release_pend", 32'(pend_o), 32'hFF);
    check("release_irq",  32'(irq_o),  32'h1);

    foreach (vecs[i]) begin
      req_i = vecs[i].req; mask_i = vecs[i].mask;
      ack_i = vecs[i].ack; ack_idx_i = vecs[i].idx;
      if (vecs[i].clk_en) @(posedge clk);
      #1;
      check({vecs[i].name, "_pend"}, 32'(pend_o), 32'(vecs[i].exp_pend));
      check({vecs[i].name, "_irq"},  32'(irq_o),  32'(vecs[i].exp_irq));
      check({vecs[i].name, "_ovf"},  32'(ovf_o),  32'(vecs[i].exp_ovf));
      if (vecs[i].name == "single") check("encoder_y", 32'(prio_enc(pend_o)), 32'd5);
    end
    ack_i = 1'b0;

    // Asynchronous reset mid-operation wipes pending and overflow at once
    #2 rst = 1'b1;
    #1;
    check("midrst_pend", 32'(pend_o), 32'h00);
    check("midrst_irq",  32'(irq_o),  32'h0);
    check("midrst_ovf",  32'(ovf_o),  32'h00);

    // A line held high across release yields exactly one event
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("relhold_pend", 32'(pend_o), 32'h20);
    @(posedge clk); #1;
    check("relhold2_pend", 32'(pend_o), 32'h20);
    check("relhold2_ovf",  32'(ovf_o),  32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
